rca_lsq_mem_responder: RTL and testbench
========================================

// Module: rca_lsq_mem_responder
// PURPOSE
// - Memory-side responder for the RCA load/store queue: accepts grid load/store requests, issues them to data memory when the CPU LSU is idle, returns load data in order.
// - Sits between rca_lsq and the data-memory port; CPU LSU traffic always has priority.
// PARAMETERS
// - XLEN            32  data/address width
// - TAG_W           3   request tag width (originating IO-unit index)
// - MAX_OUTSTANDING 4   max acked loads awaiting data (power of 2, >=2)
// PORTS
// - clk            in  1      clock
// - rst            in  1      reset: one clock; synchronous, active-high
// - lsq_req_valid  in  1      request from LSQ
// - lsq_req_ready  out 1      request accepted when valid&&ready
// - lsq_req_addr   in  XLEN   byte address
// - lsq_req_we     in  1      1=store, 0=load
// - lsq_req_be     in  4      byte enables
// - lsq_req_wdata  in  XLEN   store data
// - lsq_req_tag    in  TAG_W  tag returned with load data
// - lsq_rsp_valid  out 1      load data valid (single-cycle pulse)
// - lsq_rsp_data   out XLEN   load data
// - lsq_rsp_tag    out TAG_W  tag of returned load
// - cpu_lsu_busy   in  1      CPU LSU owns memory port this cycle
// - flush          in  1      discard all RCA memory traffic (IO-unit FIFO clear)
// - mem_req        out 1      request to memory; held until mem_ack
// - mem_addr/mem_we/mem_be/mem_wdata  out XLEN/1/4/XLEN  request fields
// - mem_ack        in  1      memory accepted request this cycle
// - mem_rvalid     in  1      load data return, in issue order
// - mem_rdata      in  XLEN   load data
// - idle           out 1      no held request, no outstanding loads, not draining
// - misalign_err   out 1      sticky misalignment flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: lsq_req_ready=0, lsq_rsp_valid=0, lsq_rsp_data=0, lsq_rsp_tag=0, mem_req=0, mem_* fields=0, idle=1, misalign_err=0; outstanding/drain counts=0, tag FIFO empty.
// - States: IDLE (no held req), HOLD (req registered, waiting to issue/ack), DRAIN (flush pending responses).
// - lsq_req_ready = state==IDLE && !flush && (lsq_req_we || outstanding<MAX_OUTSTANDING).
// - Accept: register fields; IDLE->HOLD next cycle. One request in flight at a time on request side.
// - HOLD: mem_req = !cpu_lsu_busy; fields stable. mem_ack while mem_req -> IDLE next cycle; load pushes tag into FIFO, outstanding+1.
// - cpu_lsu_busy rising while mem_req high and no ack: mem_req drops; request retried later, fields unchanged.
// - mem_rvalid: pop tag FIFO; next cycle lsq_rsp_valid=1 with mem_rdata/tag (1-cycle latency); outstanding-1.
// - Same-cycle ack(load) and rvalid: outstanding unchanged, FIFO push and pop both occur.
// - mem_rvalid with FIFO empty: ignored (assertion in sim).
// - flush: held unacked request dropped (ack in same cycle counts as accepted; load then counted outstanding). If outstanding>0 -> DRAIN, else IDLE. DRAIN: rvalid pops silently, no lsq_rsp_valid; exit to IDLE when count reaches 0. lsq_req_ready=0 in DRAIN.
// - Flush during DRAIN: no effect. Reset mid-operation: all state cleared, in-flight memory responses after reset are ignored.
// - Outstanding counter width $clog2(MAX_OUTSTANDING+1); never wraps (ready blocks loads at full).
// CONFIGURATION
// - RCA_LSQ_MISALIGN_CHECK_EN defined: accepted request with be not in {4'hF addr[1:0]==0; 4'h3/4'hC addr[1]-aligned; single bit} is consumed but not issued (no mem_req, no response); misalign_err set, cleared only by rst.
// - Undefined: no check; all requests issued unchanged; misalign_err tied 0.
// TESTING
// - Load addr 0x100 tag 2, mem_ack at once, mem_rvalid 3 cycles later data 0xDEADBEEF -> rsp_valid one cycle after rvalid, data 0xDEADBEEF, tag 2.
// - 4 loads acked, no rvalid -> lsq_req_ready=0 for load, store still accepted; one rvalid -> ready for loads returns next cycle.
// - cpu_lsu_busy high 5 cycles during HOLD -> mem_req=0 those cycles, then asserted with unchanged addr/data; single ack.
// - 3 loads outstanding + held store, flush -> store never acked/issued, 3 rvalids produce no rsp_valid, idle=1 after third.
// - Same-cycle ack(load) and rvalid with 2 outstanding -> count stays 2; tags returned in issue order.
// - Macro on: store be=4'hF addr 0x102 -> no mem_req, misalign_err=1 until rst; macro off: issued as-is.

Source files
------------

// File: rtl/rca_lsq_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : rca_lsq_mem_responder_if
// Brief    : LSQ request/response and data-memory port bundle for the
//            RCA memory responder (slave = responder view).
// Revision : 1.0 - initial release
// ============================================================================
interface rca_lsq_mem_responder_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 3
) ();
    logic             lsq_req_valid;
    logic             lsq_req_ready;
    logic [XLEN-1:0]  lsq_req_addr;
    logic             lsq_req_we;
    logic [3:0]       lsq_req_be;
    logic [XLEN-1:0]  lsq_req_wdata;
    logic [TAG_W-1:0] lsq_req_tag;
    logic             lsq_rsp_valid;
    logic [XLEN-1:0]  lsq_rsp_data;
    logic [TAG_W-1:0] lsq_rsp_tag;
    logic             cpu_lsu_busy;
    logic             flush;
    logic             mem_req;
    logic [XLEN-1:0]  mem_addr;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [XLEN-1:0]  mem_wdata;
    logic             mem_ack;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;
    logic             idle;
    logic             misalign_err;

    modport slave (
        input  lsq_req_valid, lsq_req_addr, lsq_req_we, lsq_req_be,
               lsq_req_wdata, lsq_req_tag, cpu_lsu_busy, flush,
               mem_ack, mem_rvalid, mem_rdata,
        output lsq_req_ready, lsq_rsp_valid, lsq_rsp_data, lsq_rsp_tag,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata,
               idle, misalign_err
    );

    modport master (
        output lsq_req_valid, lsq_req_addr, lsq_req_we, lsq_req_be,
               lsq_req_wdata, lsq_req_tag, cpu_lsu_busy, flush,
               mem_ack, mem_rvalid, mem_rdata,
        input  lsq_req_ready, lsq_rsp_valid, lsq_rsp_data, lsq_rsp_tag,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata,
               idle, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/rca_lsq_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : rca_lsq_mem_responder
// Brief    : Issues RCA load/store queue requests to data memory when the CPU
//            LSU is idle and returns load data in issue order with tags.
//            Optional feature macro: RCA_LSQ_MISALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rca_lsq_mem_responder #(
    parameter int XLEN            = 32,
    parameter int TAG_W           = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    rca_lsq_mem_responder_if.slave        bus
);
    localparam int c_OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_PW = $clog2(MAX_OUTSTANDING);
    localparam logic [c_OW-1:0] c_MAX_CNT = c_OW'(MAX_OUTSTANDING);
    localparam logic [c_OW-1:0] c_ONE     = c_OW'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_HOLD  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [XLEN-1:0]  r_addr;
    logic             r_we;
    logic [3:0]       r_be;
    logic [XLEN-1:0]  r_wdata;
    logic [TAG_W-1:0] r_tag;
    logic [c_OW-1:0]  r_outstanding;
    logic [c_OW-1:0]  w_outstanding_nxt;
    logic [TAG_W-1:0] r_tag_fifo [MAX_OUTSTANDING];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic             r_rsp_valid;
    logic [XLEN-1:0]  r_rsp_data;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_misalign;

    logic w_ready;
    logic w_accept;
    logic w_mem_req;
    logic w_ack;
    logic w_push;
    logic w_pop;
    logic w_rsp_fire;
    logic w_misaligned;

    assign w_ready   = !rst && (r_state == c_ST_IDLE) && !bus.flush &&
                       (bus.lsq_req_we || (r_outstanding < c_MAX_CNT));
    assign w_accept  = bus.lsq_req_valid && w_ready;
    // The CPU LSU steals the port combinationally; the held request simply retries.
    assign w_mem_req = !rst && (r_state == c_ST_HOLD) && !bus.cpu_lsu_busy;
    assign w_ack     = w_mem_req && bus.mem_ack;
    assign w_push    = w_ack && !r_we;
    assign w_pop     = bus.mem_rvalid && (r_outstanding != '0);
    assign w_rsp_fire = w_pop && (r_state != c_ST_DRAIN) && !bus.flush;

`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b1;
        case (bus.lsq_req_be)
            4'hF:                       w_misaligned = (bus.lsq_req_addr[1:0] != 2'b00);
            4'h3, 4'hC:                 w_misaligned = bus.lsq_req_addr[0];
            4'h1, 4'h2, 4'h4, 4'h8:     w_misaligned = 1'b0;
            default:                    w_misaligned = 1'b1;
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_push && !w_pop) begin
            w_outstanding_nxt = r_outstanding + c_ONE;
        end else if (!w_push && w_pop) begin
            w_outstanding_nxt = r_outstanding - c_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.flush) begin
                    w_state_nxt = (w_outstanding_nxt != '0) ? c_ST_DRAIN : c_ST_IDLE;
                end else if (w_accept && !w_misaligned) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                // An ack in the flush cycle still counts: its load joins the drain.
                if (bus.flush) begin
                    w_state_nxt = (w_outstanding_nxt != '0) ? c_ST_DRAIN : c_ST_IDLE;
                end else if (w_ack) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_DRAIN: begin
                if (w_outstanding_nxt == '0) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_tag         <= '0;
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_tag     <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_rsp_valid   <= w_rsp_fire;
            if (w_accept && !w_misaligned) begin
                r_addr  <= bus.lsq_req_addr;
                r_we    <= bus.lsq_req_we;
                r_be    <= bus.lsq_req_be;
                r_wdata <= bus.lsq_req_wdata;
                r_tag   <= bus.lsq_req_tag;
            end
            if (w_accept && w_misaligned) begin
                r_misalign <= 1'b1;
            end
            if (w_push) begin
                r_tag_fifo[r_wr_ptr] <= r_tag;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_rsp_fire) begin
                r_rsp_data <= bus.mem_rdata;
                r_rsp_tag  <= r_tag_fifo[r_rd_ptr];
            end
        end
    end

    assign bus.lsq_req_ready = w_ready;
    assign bus.lsq_rsp_valid = r_rsp_valid;
    assign bus.lsq_rsp_data  = r_rsp_data;
    assign bus.lsq_rsp_tag   = r_rsp_tag;
    assign bus.mem_req       = w_mem_req;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_we        = r_we;
    assign bus.mem_be        = r_be;
    assign bus.mem_wdata     = r_wdata;
    assign bus.idle          = (r_state == c_ST_IDLE) && (r_outstanding == '0);
    assign bus.misalign_err  = r_misalign;

    // Memory must never return data without a matching issued load.
    a_rvalid_has_tag: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rvalid |-> (r_outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_rca_lsq_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_lsq_mem_responder
// Brief    : Directed self-checking bench: cycle table for a single load plus
//            hand sequences for backpressure, busy, flush and ordering cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_lsq_mem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rca_lsq_mem_responder_if #(.XLEN(32), .TAG_W(3)) bus ();

    rca_lsq_mem_responder #(
        .XLEN            (32),
        .TAG_W           (3),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  tag;
        logic        ack;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_ready;
        logic        e_mem_req;
        logic        e_rsp_valid;
        logic        e_idle;
        logic [2:0]  e_tag;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [0:6];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.lsq_req_valid = 1'b0;
        bus.lsq_req_addr  = '0;
        bus.lsq_req_we    = 1'b0;
        bus.lsq_req_be    = 4'hF;
        bus.lsq_req_wdata = '0;
        bus.lsq_req_tag   = '0;
        bus.cpu_lsu_busy  = 1'b0;
        bus.flush         = 1'b0;
        bus.mem_ack       = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    // Accept a load, then ack it in the following cycle.
    task automatic issue_load(input logic [31:0] addr, input logic [2:0] tag);
        bus.lsq_req_valid = 1'b1;
        bus.lsq_req_we    = 1'b0;
        bus.lsq_req_addr  = addr;
        bus.lsq_req_tag   = tag;
        #2 chk1("load_ready", bus.lsq_req_ready, 1'b1);
        @(negedge clk);
        bus.lsq_req_valid = 1'b0;
        bus.mem_ack       = 1'b1;
        #2 chk1("load_mem_req", bus.mem_req, 1'b1);
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    task automatic return_data(input logic [31:0] data);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rst = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 32'h100, 3'd2, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #2;
        chk1 ("rst_ready",     bus.lsq_req_ready, 1'b0);
        chk1 ("rst_mem_req",   bus.mem_req,       1'b0);
        chk1 ("rst_rsp_valid", bus.lsq_rsp_valid, 1'b0);
        chk1 ("rst_idle",      bus.idle,          1'b1);
        chk1 ("rst_misalign",  bus.misalign_err,  1'b0);
        chk32("rst_rsp_data",  bus.lsq_rsp_data,  32'h0);
        chk32("rst_rsp_tag",   {29'd0, bus.lsq_rsp_tag}, 32'h0);
        chk32("rst_mem_addr",  bus.mem_addr,      32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single load: ack immediately, data three cycles later
        for (int i = 0; i < 7; i++) begin
            bus.lsq_req_valid = vecs[i].valid;
            bus.lsq_req_we    = vecs[i].we;
            bus.lsq_req_addr  = vecs[i].addr;
            bus.lsq_req_tag   = vecs[i].tag;
            bus.mem_ack       = vecs[i].ack;
            bus.mem_rvalid    = vecs[i].rvalid;
            bus.mem_rdata     = vecs[i].rdata;
            #2;
            chk1("vec_ready",     bus.lsq_req_ready, vecs[i].e_ready);
            chk1("vec_mem_req",   bus.mem_req,       vecs[i].e_mem_req);
            chk1("vec_rsp_valid", bus.lsq_rsp_valid, vecs[i].e_rsp_valid);
            chk1("vec_idle",      bus.idle,          vecs[i].e_idle);
            if (vecs[i].e_mem_req) begin
                chk32("vec_mem_addr", bus.mem_addr, 32'h100);
            end
            if (vecs[i].e_rsp_valid) begin
                chk32("vec_rsp_tag",  {29'd0, bus.lsq_rsp_tag}, {29'd0, vecs[i].e_tag});
                chk32("vec_rsp_data", bus.lsq_rsp_data, vecs[i].e_data);
            end
            @(negedge clk);
        end
        clear_inputs();

        // Four outstanding loads block further loads but not stores
        for (int i = 0; i < 4; i++) begin
            issue_load(32'h400 + 32'(i) * 4, 3'(i));
        end
        bus.lsq_req_valid = 1'b1;
        bus.lsq_req_we    = 1'b0;
        #2 chk1("full_load_ready", bus.lsq_req_ready, 1'b0);
        bus.lsq_req_we    = 1'b1;
        bus.lsq_req_wdata = 32'hCAFE0001;
        #1 chk1("full_store_ready", bus.lsq_req_ready, 1'b1);
        @(negedge clk);
        bus.lsq_req_valid = 1'b0;
        bus.lsq_req_we    = 1'b0;
        bus.mem_ack       = 1'b1;
        #2;
        chk1("full_store_req", bus.mem_req, 1'b1);
        chk1("full_store_we",  bus.mem_we,  1'b1);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #2 chk1("full_still_blocked", bus.lsq_req_ready, 1'b0);
        @(negedge clk);
        return_data(32'h11110000);
        chk1 ("full_ready_back", bus.lsq_req_ready, 1'b1);
        chk1 ("full_rsp_valid",  bus.lsq_rsp_valid, 1'b1);
        chk32("full_rsp_tag",    {29'd0, bus.lsq_rsp_tag}, 32'd0);
        chk32("full_rsp_data",   bus.lsq_rsp_data, 32'h11110000);
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            return_data(32'h11110000 + 32'(j));
            chk32("order_rsp_tag",  {29'd0, bus.lsq_rsp_tag}, 32'(j));
            chk32("order_rsp_data", bus.lsq_rsp_data, 32'h11110000 + 32'(j));
        end
        chk1("order_idle", bus.idle, 1'b1);
        @(negedge clk);

        // CPU LSU busy during HOLD: request withdrawn then retried unchanged
        bus.lsq_req_valid = 1'b1;
        bus.lsq_req_we    = 1'b1;
        bus.lsq_req_addr  = 32'h200;
        bus.lsq_req_wdata = 32'h12345678;
        @(negedge clk);
        clear_inputs();
        #2 chk1("busy_first_req", bus.mem_req, 1'b1);
        @(negedge clk);
        bus.cpu_lsu_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2 chk1("busy_req_low", bus.mem_req, 1'b0);
            @(negedge clk);
        end
        bus.cpu_lsu_busy = 1'b0;
        #2;
        chk1 ("busy_retry_req", bus.mem_req,   1'b1);
        chk32("busy_addr",      bus.mem_addr,  32'h200);
        chk32("busy_wdata",     bus.mem_wdata, 32'h12345678);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #2;
        chk1("busy_after_ack_req", bus.mem_req, 1'b0);
        chk1("busy_after_ack_idle", bus.idle,   1'b1);
        @(negedge clk);

        // Flush with three loads outstanding and a held store
        issue_load(32'h500, 3'd4);
        issue_load(32'h504, 3'd5);
        issue_load(32'h508, 3'd6);
        bus.lsq_req_valid = 1'b1;
        bus.lsq_req_we    = 1'b1;
        bus.lsq_req_addr  = 32'h600;
        @(negedge clk);
        bus.lsq_req_valid = 1'b0;
        bus.cpu_lsu_busy  = 1'b1;
        bus.flush         = 1'b1;
        @(negedge clk);
        bus.flush         = 1'b0;
        bus.cpu_lsu_busy  = 1'b0;
        #2;
        chk1("drain_ready",   bus.lsq_req_ready, 1'b0);
        chk1("drain_mem_req", bus.mem_req,       1'b0);
        chk1("drain_idle",    bus.idle,          1'b0);
        bus.lsq_req_we = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            return_data(32'hBAD00000 + 32'(j));
            chk1("drain_no_rsp",  bus.lsq_rsp_valid, 1'b0);
            chk1("drain_no_req",  bus.mem_req,       1'b0);
            chk1("drain_idle_seq", bus.idle, (j == 2));
        end
        chk1("drain_ready_back", bus.lsq_req_ready, 1'b1);
        @(negedge clk);

        // Same-cycle ack and rvalid with two loads outstanding
        issue_load(32'h700, 3'd1);
        issue_load(32'h704, 3'd2);
        bus.lsq_req_valid = 1'b1;
        bus.lsq_req_addr  = 32'h708;
        bus.lsq_req_tag   = 3'd3;
        @(negedge clk);
        bus.lsq_req_valid = 1'b0;
        bus.mem_ack       = 1'b1;
        bus.mem_rvalid    = 1'b1;
        bus.mem_rdata     = 32'hA5A5A5A5;
        #2 chk1("same_mem_req", bus.mem_req, 1'b1);
        @(negedge clk);
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        #2;
        chk1 ("same_rsp_valid", bus.lsq_rsp_valid, 1'b1);
        chk32("same_rsp_tag",   {29'd0, bus.lsq_rsp_tag}, 32'd1);
        chk32("same_rsp_data",  bus.lsq_rsp_data, 32'hA5A5A5A5);
        @(negedge clk);
        return_data(32'hB0B0B0B0);
        chk32("same_tag2", {29'd0, bus.lsq_rsp_tag}, 32'd2);
        chk1 ("same_idle2", bus.idle, 1'b0);
        @(negedge clk);
        return_data(32'hC0C0C0C0);
        chk32("same_tag3", {29'd0, bus.lsq_rsp_tag}, 32'd3);
        chk1 ("same_idle3", bus.idle, 1'b1);
        @(negedge clk);

        // Misaligned full-word store
        bus.lsq_req_valid = 1'b1;
        bus.lsq_req_we    = 1'b1;
        bus.lsq_req_be    = 4'hF;
        bus.lsq_req_addr  = 32'h102;
        bus.lsq_req_wdata = 32'h0BADF00D;
        #2 chk1("mis_ready", bus.lsq_req_ready, 1'b1);
        @(negedge clk);
        clear_inputs();
        #2;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
        chk1("mis_no_req",  bus.mem_req,      1'b0);
        chk1("mis_flag",    bus.misalign_err, 1'b1);
        chk1("mis_idle",    bus.idle,         1'b1);
        @(negedge clk);
        #2;
        chk1("mis_no_req2", bus.mem_req,      1'b0);
        chk1("mis_sticky",  bus.misalign_err, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2 chk1("mis_cleared", bus.misalign_err, 1'b0);
`else
        chk1 ("mis_issued",   bus.mem_req,      1'b1);
        chk32("mis_addr",     bus.mem_addr,     32'h102);
        chk32("mis_be",       {28'd0, bus.mem_be}, 32'hF);
        chk1 ("mis_no_flag",  bus.misalign_err, 1'b0);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #2 chk1("mis_done_idle", bus.idle, 1'b1);
`endif
        @(negedge clk);

        // Reset in the middle of an outstanding load
        issue_load(32'h800, 3'd7);
        #2 chk1("midrst_busy", bus.idle, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk1("midrst_idle",  bus.idle,          1'b1);
        chk1("midrst_ready", bus.lsq_req_ready, 1'b1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
